// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART FIFO bridge: RX FSM states,
// status word bit positions and the value returned by a read of an empty RX FIFO.
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_ACK   = 2'd1,
    RX_GUARD = 2'd2
  } rx_state_e;

  localparam int STAT_TX_CNT_LSB = 0;
  localparam int STAT_RX_CNT_LSB = 8;
  localparam int STAT_TX_FULL    = 16;
  localparam int STAT_TX_EMPTY   = 17;
  localparam int STAT_RX_FULL    = 18;
  localparam int STAT_RX_EMPTY   = 19;

  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

  function automatic logic [31:0] pack_status(
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt,
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty
  );
    logic [31:0] s;
    s                           = '0;
    s[STAT_TX_CNT_LSB +: 8]     = tx_cnt;
    s[STAT_RX_CNT_LSB +: 8]     = rx_cnt;
    s[STAT_TX_FULL]             = tx_full;
    s[STAT_TX_EMPTY]            = tx_empty;
    s[STAT_RX_FULL]             = rx_full;
    s[STAT_RX_EMPTY]            = rx_empty;
    return s;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// 8-bit synchronous FIFO, 2**DEPTH_LOG2 entries. Push into a full FIFO and
// pop from an empty FIFO are ignored; push and pop may occur together.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_push,
  input  logic [7:0]            i_din,
  input  logic                  i_pop,
  output logic [7:0]            o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU <-> simple-UART buffering bridge with TX and RX FIFOs, status word and irq.
// Define UART_FIFO_RX_THRESH_EN to raise irq_out at an RX fill threshold instead of non-empty.
module uart_fifo_bridge
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int RX_IRQ_LEVEL = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  output logic [31:0] reg_stat_do,
  output logic        uart_dat_we,
  output logic [31:0] uart_dat_di,
  input  logic        uart_dat_wait,
  output logic        uart_dat_re,
  input  logic [31:0] uart_dat_do,
  input  logic        uart_rx_valid,
  output logic        irq_out
);

  localparam int CW = DEPTH_LOG2 + 1;

  logic [7:0]    w_tx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic          w_tx_pop;
  logic [7:0]    w_rx_head;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic          w_rx_push;
  logic          w_irq_next;
  logic          w_unused_bits;

  rx_state_e     r_rx_state;
  logic          r_uart_dat_re;
  logic          r_irq;

  // A full FIFO stalls the CPU even if it drains this cycle; the CPU retries.
  assign reg_dat_wait = reg_dat_we && w_tx_full;
  assign uart_dat_we  = !w_tx_empty;
  assign uart_dat_di  = {24'b0, w_tx_head};
  assign w_tx_pop     = uart_dat_we && !uart_dat_wait;

  uart_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (reg_dat_we && !w_tx_full),
    .i_din   (reg_dat_di[7:0]),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  assign w_rx_push = (r_rx_state == RX_ACK);

  uart_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_rx_push),
    .i_din   (uart_dat_do[7:0]),
    .i_pop   (reg_dat_re),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // The guard cycle lets the UART's valid flag settle after the acknowledge
  // so the same byte is never fetched twice.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_state    <= RX_IDLE;
      r_uart_dat_re <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (uart_rx_valid && !w_rx_full) begin
            r_rx_state    <= RX_ACK;
            r_uart_dat_re <= 1'b1;
          end
        end
        RX_ACK: begin
          r_rx_state    <= RX_GUARD;
          r_uart_dat_re <= 1'b0;
        end
        RX_GUARD: begin
          r_rx_state <= RX_IDLE;
        end
        default: begin
          r_rx_state    <= RX_IDLE;
          r_uart_dat_re <= 1'b0;
        end
      endcase
    end
  end

  assign uart_dat_re = r_uart_dat_re;

`ifdef UART_FIFO_RX_THRESH_EN
  assign w_irq_next = (w_rx_count >= CW'(RX_IRQ_LEVEL));
`else
  localparam int unused_irq_level = RX_IRQ_LEVEL;
  assign w_irq_next = !w_rx_empty;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_next;
    end
  end

  assign irq_out     = r_irq;
  assign reg_dat_do  = w_rx_empty ? EMPTY_READ : {24'b0, w_rx_head};
  assign reg_stat_do = pack_status(8'(w_tx_count), 8'(w_rx_count),
                                   w_tx_full, w_tx_empty, w_rx_full, w_rx_empty);

  assign w_unused_bits = ^{reg_dat_di[31:8], uart_dat_do[31:8]};

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Buffering stage between the CPU bus data register and the simple UART's data-register interface.
- TX FIFO accepts CPU bytes and drains them into the UART write port, obeying its wait handshake.
- RX FIFO pulls received bytes out of the UART's single-byte buffer, so back-to-back characters are not lost while the CPU is busy.
- Status word and interrupt are exposed to the CPU.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth; 16 entries per FIFO.
- RX_IRQ_LEVEL, 8, RX fill level that raises irq_out; used only with the optional feature.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- reg_dat_we  in  1  CPU write strobe; pushes reg_dat_di[7:0] into TX FIFO
- reg_dat_re  in  1  CPU read strobe; pops RX FIFO
- reg_dat_di  in  32  CPU write data; bits [7:0] used
- reg_dat_do  out  32  RX head byte zero-extended, or 32'hFFFFFFFF when RX empty
- reg_dat_wait  out  1  CPU stall; equals reg_dat_we && tx_full
- reg_stat_do  out  32  status word
- uart_dat_we  out  1  write strobe to UART
- uart_dat_di  out  32  {24'b0, TX head byte} to UART
- uart_dat_wait  in  1  UART busy stall; combinational on uart_dat_we
- uart_dat_re  out  1  read-acknowledge strobe to UART
- uart_dat_do  in  32  UART receive data; valid while uart_rx_valid
- uart_rx_valid  in  1  UART receive-buffer-valid (the UART irq line)
- irq_out  out  1  CPU interrupt

Behaviour:
- Reset (resetn low at a clk edge):
  - Both FIFOs are emptied: pointers and counts go to 0.
  - The RX FSM goes to RX_IDLE.
  - All outputs go to their reset values: uart_dat_we=0, uart_dat_re=0, irq_out=0, reg_dat_do=all ones, reg_stat_do shows both FIFOs empty.
  - A byte left in the UART buffer is kept and is fetched after reset is released.
- CPU write:
  - When reg_dat_we=1 and the TX FIFO is not full, the byte is pushed at the clk edge.
  - When the TX FIFO is full, reg_dat_wait=1 and nothing is pushed. This holds even if the FIFO drains in the same cycle; the CPU retries next cycle.
- TX drain (no FSM):
  - uart_dat_we = tx_not_empty; uart_dat_di carries the TX head byte.
  - The head is popped at the edge where uart_dat_we && !uart_dat_wait.
  - One byte is accepted per UART frame; the FIFO never pops while wait=1.
  - A CPU push and a drain pop in the same cycle leave the count unchanged.
- RX FSM, states RX_IDLE, RX_ACK, RX_GUARD:
  - RX_IDLE -> RX_ACK when uart_rx_valid && !rx_full.
  - RX_ACK:
    - uart_dat_re=1 for exactly this cycle.
    - uart_dat_do[7:0] is pushed into the RX FIFO at this edge.
    - Next state is RX_GUARD.
  - RX_GUARD: one dead cycle, so the UART's valid flag reflects the acknowledge (or a new byte landing the same cycle); then -> RX_IDLE.
  - When the RX FIFO is full, the byte stays in the UART. Only if the UART then overwrites it is a byte lost; the bridge does not flag this.
- CPU read:
  - reg_dat_do is combinational from the RX head.
  - reg_dat_re pops the RX head when not empty.
  - A read from an empty FIFO has no effect and returns all ones.
  - An RX push and a CPU pop in the same cycle are both honoured.
- Width rules:
  - Counts are DEPTH_LOG2+1 bits wide; full = (count == 2**DEPTH_LOG2).
  - Pointers are DEPTH_LOG2 bits and wrap modulo the depth.
- reg_stat_do layout:
  - [7:0] tx_count, zero-extended
  - [15:8] rx_count
  - [16] tx_full
  - [17] tx_empty
  - [18] rx_full
  - [19] rx_empty
  - others 0
- irq_out is registered, one cycle behind the FIFO state.

Optional Feature:
- Macro: UART_FIFO_RX_THRESH_EN.
- Defined: irq_out = (rx_count >= RX_IRQ_LEVEL).
- Undefined: irq_out = !rx_empty, and RX_IRQ_LEVEL is ignored.

Decomposition:
- Package uart_fifo_pkg holds:
  - RX FSM state enum (RX_IDLE, RX_ACK, RX_GUARD)
  - status bit-position constants
  - the empty-read value 32'hFFFFFFFF
- Sub-module uart_sync_fifo: parameterised 8-bit-wide synchronous FIFO with push/pop, full/empty and count. It is instantiated twice, once for TX and once for RX.

Test Plan:
1. Write 0x41,0x42,0x43 while the UART is busy (wait=1 for 5 cycles) -> uart_dat_we is held high with di=0x41; pops occur only on cycles with wait=0; bytes leave in order 41,42,43.
2. Write 17 bytes with wait held at 1 -> the first 16 are accepted; reg_dat_wait=1 on the 17th; stat[16]=1 and stat[7:0]=16.
3. Pulse uart_rx_valid with 0x5A, then 0xA5 four cycles later -> each is acknowledged by a single uart_dat_re pulse with a guard cycle after it; the CPU reads 0x5A then 0xA5; a third read returns 0xFFFFFFFF.
4. Fill the RX FIFO to 16 with uart_rx_valid still high -> uart_dat_re is not asserted; after one CPU read, the bridge acknowledges within 2 cycles and rx_count returns to 16.
5. With UART_FIFO_RX_THRESH_EN and RX_IRQ_LEVEL=3, receive 3 bytes -> irq_out stays 0 after bytes 1 and 2 and rises one cycle after the 3rd push; it drops after one read. Without the macro, irq_out rises after the 1st byte.
6. Assert resetn=0 for one cycle with 5 bytes in TX, 3 in RX, and the FSM in RX_ACK -> stat shows both empty and uart_dat_we=0, uart_dat_re=0, irq_out=0 on the next cycle; a pending uart_rx_valid is fetched after release.
